// File: rtl/fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module fifo_flagged #(
  parameter int DATA_WIDTH         = 8,
  parameter int FIFO_ASIZE         = 4,
  parameter int ALMOST_FULL_LEVEL  = (1 << FIFO_ASIZE) - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  parameter bit FWFT               = 1'b0
) (
  input  logic                  in_clock,
  input  logic                  in_reset,
  input  logic                  in_flush,
  input  logic                  in_put,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_take,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_empty,
  output logic                  out_full,
  output logic                  out_almost_empty,
  output logic                  out_almost_full,
  output logic [FIFO_ASIZE:0]   out_count,
  output logic                  out_overflow,
  output logic                  out_underflow
);
  localparam int DEPTH = 1 << FIFO_ASIZE;
  localparam int CW    = FIFO_ASIZE + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_LEVEL);

  logic [FIFO_ASIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_ASIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  full, empty, put_acc, take_acc;

  // Handshake: a request is accepted in the cycle it is high and the count
  // permits it (put needs not-full, take needs not-empty, both judged on the
  // registered count); a rejected request is dropped and only sets its sticky
  // error flag. Flush overrides both requests.
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign put_acc  = in_put  & ~full  & ~in_flush;
  assign take_acc = in_take & ~empty & ~in_flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (in_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (put_acc)  wr_ptr_d = wr_ptr_q + FIFO_ASIZE'(1);
      if (take_acc) rd_ptr_d = rd_ptr_q + FIFO_ASIZE'(1);
      case ({put_acc, take_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (in_put & full)   overflow_d  = 1'b1;
      if (in_take & empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; only the pointers and count define what is valid.
  always_ff @(posedge in_clock) begin
    if (put_acc & ~in_reset) mem_q[wr_ptr_q] <= in_data;
  end

  generate
    if (FWFT) begin : g_fwft
      assign out_data = mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      always_ff @(posedge in_clock) begin
        if (in_reset)      rd_data_q <= '0;
        else if (take_acc) rd_data_q <= mem_q[rd_ptr_q];
      end
      assign out_data = rd_data_q;
    end
  endgenerate

  assign out_empty        = empty;
  assign out_full         = full;
  assign out_almost_empty = (count_q <= AE_C);
  assign out_almost_full  = (count_q >= AF_C);
  assign out_count        = count_q;
  assign out_overflow     = overflow_q;
  assign out_underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flagged.sv
// Directed bench for fifo_flagged: a registered-read and an FWFT instance
// share the same stimulus; outputs are checked #1 after each rising edge.
module tb_fifo_flagged;
  logic       clk = 1'b0;
  logic       rst, flush, put, take;
  logic [7:0] din;

  logic [7:0] d0_data, d1_data;
  logic       d0_empty, d0_full, d0_ae, d0_af, d0_ovf, d0_udf;
  logic       d1_empty, d1_full, d1_ae, d1_af, d1_ovf, d1_udf;
  logic [4:0] d0_count, d1_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_r;
  logic       exp_ovf, exp_udf;

  always #5 clk = ~clk;

  fifo_flagged #(.DATA_WIDTH(8), .FIFO_ASIZE(4), .ALMOST_FULL_LEVEL(14),
                 .ALMOST_EMPTY_LEVEL(2), .FWFT(1'b0)) dut0 (
    .in_clock(clk), .in_reset(rst), .in_flush(flush), .in_put(put),
    .in_data(din), .in_take(take), .out_data(d0_data), .out_empty(d0_empty),
    .out_full(d0_full), .out_almost_empty(d0_ae), .out_almost_full(d0_af),
    .out_count(d0_count), .out_overflow(d0_ovf), .out_underflow(d0_udf));

  fifo_flagged #(.DATA_WIDTH(8), .FIFO_ASIZE(4), .ALMOST_FULL_LEVEL(14),
                 .ALMOST_EMPTY_LEVEL(2), .FWFT(1'b1)) dut1 (
    .in_clock(clk), .in_reset(rst), .in_flush(flush), .in_put(put),
    .in_data(din), .in_take(take), .out_data(d1_data), .out_empty(d1_empty),
    .out_full(d1_full), .out_almost_empty(d1_ae), .out_almost_full(d1_af),
    .out_count(d1_count), .out_overflow(d1_ovf), .out_underflow(d1_udf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, then sample #1 after the consuming edge.
  task automatic step(input logic p, input logic t, input logic [7:0] d, input logic f);
    put = p; take = t; din = d; flush = f;
    @(posedge clk); #1;
    put = 1'b0; take = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; put = 1'b0; take = 1'b0; din = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", d0_count, 0);
    chk("rst_empty", d0_empty, 1);
    chk("rst_full", d0_full, 0);
    chk("rst_ae", d0_ae, 1);
    chk("rst_af", d0_af, 0);
    chk("rst_ovf", d0_ovf, 0);
    chk("rst_udf", d0_udf, 0);
    chk("rst_data", d0_data, 8'h00);
    rst = 1'b0;

    // Fill 0x00..0x0F, watching the thresholds cross at 3 and 14.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      chk("fill_count", d0_count, i + 1);
      chk("fill_ae", d0_ae, (i + 1) <= 2);
      chk("fill_af", d0_af, (i + 1) >= 14);
      if (i == 0) begin
        chk("fill_first_empty", d0_empty, 0);
        chk("fill_first_fwft", d1_data, 8'h00);
      end
    end
    chk("full_flag", d0_full, 1);

    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf_set", d0_ovf, 1);
    chk("ovf_count", d0_count, 16);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      chk("ovf_hold", d0_ovf, 1);
    end

    // Drain: registered data lands one edge after each take; 0xAA never appears.
    for (int i = 0; i < 16; i++) begin
      chk("drain_fwft_head", d1_data, 8'(i));
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("drain_data", d0_data, 8'(i));
      chk("drain_count", d0_count, 15 - i);
      chk("drain_af", d0_af, (15 - i) >= 14);
    end
    chk("drain_empty", d0_empty, 1);
    chk("drain_ovf_sticky", d0_ovf, 1);

    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_set", d0_udf, 1);
    chk("udf_data_hold", d0_data, 8'h0F);
    chk("udf_count", d0_count, 0);

    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("flush_ovf", d0_ovf, 0);
    chk("flush_udf", d0_udf, 0);
    chk("flush_count", d0_count, 0);
    chk("flush_data_hold", d0_data, 8'h0F);

    // Simultaneous put+take while empty: only the put lands.
    step(1'b1, 1'b1, 8'h11, 1'b0);
    chk("sim0_count", d0_count, 1);
    chk("sim0_udf", d0_udf, 1);
    chk("sim0_data_hold", d0_data, 8'h0F);
    chk("sim0_fwft", d1_data, 8'h11);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous at count 5: count holds, order preserved.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b1, 8'h25, 1'b0);
    chk("sim5_count", d0_count, 5);
    chk("sim5_data", d0_data, 8'h20);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("sim5_drain", d0_data, 8'(8'h20 + i));
    end
    chk("sim5_empty", d0_empty, 1);

    // Simultaneous at count 16: only the take lands.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
    step(1'b1, 1'b1, 8'h99, 1'b0);
    chk("sim16_count", d0_count, 15);
    chk("sim16_ovf", d0_ovf, 1);
    chk("sim16_data", d0_data, 8'h30);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("sim16_drain", d0_data, 8'(8'h30 + i));
    end
    chk("sim16_empty", d0_empty, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // FWFT head presentation.
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("fwft_empty", d1_empty, 0);
    chk("fwft_head", d1_data, 8'h3C);
    step(1'b1, 1'b0, 8'h5A, 1'b0);
    chk("fwft_head_hold", d1_data, 8'h3C);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_next", d1_data, 8'h5A);
    chk("fwft_reg_data", d0_data, 8'h3C);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_reg_data2", d0_data, 8'h5A);
    chk("fwft_drained", d1_empty, 1);

    // Random traffic across pointer wrap against a queue model.
    exp_r = 8'h5A; exp_ovf = 1'b0; exp_udf = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic p, t;
      logic [7:0] d;
      p = ($urandom_range(0, 9) < 7);
      t = ($urandom_range(0, 9) < 5);
      d = 8'($urandom_range(0, 255));
      if (p && exp_q.size() == 16) exp_ovf = 1'b1;
      if (t && exp_q.size() == 0)  exp_udf = 1'b1;
      if (t && exp_q.size() != 0) begin
        exp_r = exp_q.pop_front();
        if (p) exp_q.push_back(d);
      end else if (p && exp_q.size() != 16) begin
        exp_q.push_back(d);
      end
      step(p, t, d, 1'b0);
      chk("rand_count", d0_count, exp_q.size());
      chk("rand_data", d0_data, exp_r);
      chk("rand_ovf", d0_ovf, exp_ovf);
      chk("rand_udf", d0_udf, exp_udf);
      if (exp_q.size() != 0) chk("rand_fwft", d1_data, exp_q[0]);
    end

    while (exp_q.size() > 7) begin
      exp_r = exp_q.pop_front();
      step(1'b0, 1'b1, 8'h00, 1'b0);
    end
    while (exp_q.size() < 7) begin
      exp_q.push_back(8'hC3);
      step(1'b1, 1'b0, 8'hC3, 1'b0);
    end
    chk("pre_rst_count", d0_count, 7);
    chk("pre_rst_data", d0_data, exp_r);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_count", d0_count, 0);
    chk("midrst_empty", d0_empty, 1);
    chk("midrst_data", d0_data, 8'h00);
    chk("midrst_ae", d0_ae, 1);
    chk("midrst_fwft_empty", d1_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
